// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32 control path.
// Holds the opcode constants, the ALUOp encoding and the 4-bit FSM state enum.
// Build option: ILLEGAL_TRAP_EN adds the StTrap state used for unknown opcodes.
package riscv_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
`ifdef ILLEGAL_TRAP_EN
    ,
    StTrap     = 4'd11
`endif
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder.
// Ports:
//   i_alu_op      ALUOp from the controller FSM (add / sub / funct3-decoded)
//   i_funct3      instruction funct3 field
//   i_funct7b5    instruction bit 30
//   i_op5         opcode bit 5 (distinguishes R-type from I-type)
//   o_alu_control 3-bit ALU operation select
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_e    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  // Only R-type can subtract; for addi bit 30 is part of the immediate.
  logic w_sub;
  assign w_sub = i_op5 & i_funct7b5;

  always_comb begin
    o_alu_control = 3'b000;
    case (i_alu_op)
      AluOpAdd: o_alu_control = 3'b000;
      AluOpSub: o_alu_control = 3'b001;
      AluOpFunct: begin
        case (i_funct3)
          3'b000:  o_alu_control = w_sub ? 3'b001 : 3'b000;
          3'b010:  o_alu_control = 3'b101;  // slt
          3'b100:  o_alu_control = 3'b100;  // xor
          3'b110:  o_alu_control = 3'b011;  // or
          3'b111:  o_alu_control = 3'b010;  // and
          default: o_alu_control = 3'b000;
        endcase
      end
      default: o_alu_control = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore-FSM controller for a multicycle RV32 datapath.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   op, funct3, funct7b5    instruction fields
//   Zero                    ALU zero flag (branch resolve)
//   MemReady                memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   1-bit controls
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc            2-bit selects
//   ALUControl              3-bit ALU operation
//   State                   current FSM state (debug)
//   Illegal                 unknown opcode trapped
// Build option: ILLEGAL_TRAP_EN sends unknown opcodes to a sticky trap state;
// without it they are treated as nops and Illegal is tied low.
module mc_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       Illegal
);

  state_e  r_state;
  state_e  w_state_next;
  alu_op_e w_alu_op;
  logic    w_pc_update;
  logic    w_branch;
  logic    w_ir_write;
  logic    w_reg_write;
  logic    w_mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StFetch;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_alu_op     = AluOpAdd;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    case (r_state)
      StFetch: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_ir_write  = MemReady;
        w_pc_update = MemReady;
        if (MemReady) w_state_next = StDecode;
      end
      StDecode: begin
        // Precompute PC + imm so BEQ can use it as the branch target.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLoad, OpStore: w_state_next = StMemAdr;
          OpRtype:         w_state_next = StExecR;
          OpItype:         w_state_next = StExecI;
          OpBranch:        w_state_next = StBeq;
          OpJal:           w_state_next = StJal;
`ifdef ILLEGAL_TRAP_EN
          default:         w_state_next = StTrap;
`else
          default:         w_state_next = StFetch;
`endif
        endcase
      end
      StMemAdr: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        w_state_next = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (MemReady) w_state_next = StMemWb;
      end
      StMemWb: begin
        ResultSrc    = 2'b01;
        w_reg_write  = 1'b1;
        w_state_next = StFetch;
      end
      StMemWrite: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
        if (MemReady) w_state_next = StFetch;
      end
      StExecR: begin
        ALUSrcA      = 2'b10;
        w_alu_op     = AluOpFunct;
        w_state_next = StAluWb;
      end
      StExecI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        w_alu_op     = AluOpFunct;
        w_state_next = StAluWb;
      end
      StAluWb: begin
        w_reg_write  = 1'b1;
        w_state_next = StFetch;
      end
      StBeq: begin
        ALUSrcA      = 2'b10;
        w_alu_op     = AluOpSub;
        w_branch     = 1'b1;
        w_state_next = StFetch;
      end
      StJal: begin
        // ALU forms PC + 4 for the link register while PC takes the target.
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        w_pc_update  = 1'b1;
        w_state_next = StAluWb;
      end
`ifdef ILLEGAL_TRAP_EN
      StTrap: w_state_next = StTrap;
`endif
      default: w_state_next = StFetch;
    endcase
  end

  // Gate write enables with reset so an in-flight FETCH cannot commit.
  assign PCWrite  = ~reset & (w_pc_update | (w_branch & Zero));
  assign IRWrite  = ~reset & w_ir_write;
  assign RegWrite = ~reset & w_reg_write;
  assign MemWrite = ~reset & w_mem_write;
  assign State    = r_state;

`ifdef ILLEGAL_TRAP_EN
  assign Illegal = (r_state == StTrap);
`else
  assign Illegal = 1'b0;
`endif

  always_comb begin
    case (op)
      OpLoad, OpItype: ImmSrc = 2'b00;
      OpStore:         ImmSrc = 2'b01;
      OpBranch:        ImmSrc = 2'b10;
      OpJal:           ImmSrc = 2'b11;
      default:         ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op     (w_alu_op),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_op5        (op[5]),
    .o_alu_control(ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction walks with
// literal expectations, then randomized traffic checked every cycle against
// an instruction-level step-list model.
module tb_mc_controller;
  import riscv_pkg::*;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic       Illegal;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUControl(ALUControl),
    .State     (State),
    .Illegal   (Illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instruction is a list of steps; waits happen only on memory steps.
  typedef enum int {KFetch, KDecode, KMemAdr, KMemRead, KMemWb, KMemWrite,
                    KExecR, KExecI, KAluWb, KBeq, KJal, KTrap} kind_e;
  kind_e cur = KFetch;
  kind_e pend[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur = KFetch;
      pend.delete();
    end else if (cur == KTrap) begin
      cur = KTrap;
    end else if ((cur == KFetch || cur == KMemRead || cur == KMemWrite) && !MemReady) begin
      cur = cur;
    end else begin
      if (cur == KFetch) begin
        pend.delete();
        pend.push_back(KDecode);
        case (op)
          7'b0000011: begin pend.push_back(KMemAdr); pend.push_back(KMemRead);
                            pend.push_back(KMemWb); end
          7'b0100011: begin pend.push_back(KMemAdr); pend.push_back(KMemWrite); end
          7'b0110011: begin pend.push_back(KExecR); pend.push_back(KAluWb); end
          7'b0010011: begin pend.push_back(KExecI); pend.push_back(KAluWb); end
          7'b1100011: pend.push_back(KBeq);
          7'b1101111: begin pend.push_back(KJal); pend.push_back(KAluWb); end
          default: if (TrapEn) pend.push_back(KTrap);
        endcase
      end
      if (pend.size() == 0) cur = KFetch;
      else cur = pend.pop_front();
    end
  end

  function automatic logic [3:0] kind_state(input kind_e k);
    case (k)
      KFetch:    return StFetch;
      KDecode:   return StDecode;
      KMemAdr:   return StMemAdr;
      KMemRead:  return StMemRead;
      KMemWb:    return StMemWb;
      KMemWrite: return StMemWrite;
      KExecR:    return StExecR;
      KExecI:    return StExecI;
      KAluWb:    return StAluWb;
      KBeq:      return StBeq;
      KJal:      return StJal;
`ifdef ILLEGAL_TRAP_EN
      KTrap:     return StTrap;
`endif
      default:   return 4'hf;
    endcase
  endfunction

  // ALU op per funct3 when decoding by function field (add/sub handled apart).
  localparam logic [2:0] F3Ctl [8] = '{3'b000, 3'b000, 3'b101, 3'b000,
                                       3'b100, 3'b000, 3'b011, 3'b010};

  always @(negedge clk) begin
    logic       e_pcu, e_br, e_adr, e_mw, e_ir, e_rw, e_ill;
    logic [1:0] e_rs, e_a, e_b, e_aluop, e_imm;
    logic [2:0] e_ctl;
    if (armed) begin
      {e_pcu, e_br, e_adr, e_mw, e_ir, e_rw, e_ill} = '0;
      {e_rs, e_a, e_b, e_aluop} = '0;
      case (cur)
        KFetch:    begin e_b = 2'b10; e_rs = 2'b10; e_ir = MemReady; e_pcu = MemReady; end
        KDecode:   begin e_a = 2'b01; e_b = 2'b01; end
        KMemAdr:   begin e_a = 2'b10; e_b = 2'b01; end
        KMemRead:  e_adr = 1'b1;
        KMemWb:    begin e_rs = 2'b01; e_rw = 1'b1; end
        KMemWrite: begin e_adr = 1'b1; e_mw = 1'b1; end
        KExecR:    begin e_a = 2'b10; e_aluop = 2'b10; end
        KExecI:    begin e_a = 2'b10; e_b = 2'b01; e_aluop = 2'b10; end
        KAluWb:    e_rw = 1'b1;
        KBeq:      begin e_a = 2'b10; e_aluop = 2'b01; e_br = 1'b1; end
        KJal:      begin e_a = 2'b01; e_b = 2'b10; e_pcu = 1'b1; end
        default:   e_ill = 1'b1;
      endcase
      if (e_aluop == 2'b01) e_ctl = 3'b001;
      else if (e_aluop == 2'b10)
        e_ctl = (funct3 == 3'b000) ? {2'b00, op[5] & funct7b5} : F3Ctl[funct3];
      else e_ctl = 3'b000;
      case (op)
        7'b0100011: e_imm = 2'b01;
        7'b1100011: e_imm = 2'b10;
        7'b1101111: e_imm = 2'b11;
        default:    e_imm = 2'b00;
      endcase
      chk("m_state",    State,      kind_state(cur));
      chk("m_pcwrite",  PCWrite,    !reset && (e_pcu || (e_br && Zero)));
      chk("m_irwrite",  IRWrite,    !reset && e_ir);
      chk("m_regwrite", RegWrite,   !reset && e_rw);
      chk("m_memwrite", MemWrite,   !reset && e_mw);
      chk("m_adrsrc",   AdrSrc,     e_adr);
      chk("m_resultsrc", ResultSrc, e_rs);
      chk("m_alusrca",  ALUSrcA,    e_a);
      chk("m_alusrcb",  ALUSrcB,    e_b);
      chk("m_aluctl",   ALUControl, e_ctl);
      chk("m_immsrc",   ImmSrc,     e_imm);
      chk("m_illegal",  Illegal,    e_ill);
    end
  end

  // ---------------- stimulus ----------------
  task automatic adv(input logic mr);
    @(posedge clk);
    #2;
    MemReady = mr;
    @(negedge clk);
  endtask

  initial begin
    int mw_cnt;
    int rw_cnt;
    reset = 1'b1; op = OpLoad; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    MemReady = 1'b1;
    @(negedge clk);
    chk("rst_state", State, 4'h0);
    chk("rst_pcwrite", PCWrite, 1'b0);
    chk("rst_irwrite", IRWrite, 1'b0);
    chk("rst_illegal", Illegal, 1'b0);
    armed = 1'b1;

    // lw with memory always ready
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    chk("lw_fetch_state", State, 4'd0);
    chk("lw_fetch_irwrite", IRWrite, 1'b1);
    chk("lw_fetch_pcwrite", PCWrite, 1'b1);
    adv(1'b1); chk("lw_decode", State, 4'd1);
    adv(1'b1); chk("lw_memadr", State, 4'd2);
    adv(1'b1); chk("lw_memread", State, 4'd3); chk("lw_memread_rw", RegWrite, 1'b0);
    adv(1'b1); chk("lw_memwb", State, 4'd4); chk("lw_memwb_rw", RegWrite, 1'b1);
    chk("lw_memwb_rs", ResultSrc, 2'b01);
    adv(1'b1); chk("lw_back_fetch", State, 4'd0);

    // sw with a three-cycle memory stall
    op = OpStore;
    adv(1'b1); chk("sw_decode", State, 4'd1); chk("sw_immsrc", ImmSrc, 2'b01);
    adv(1'b1); chk("sw_memadr", State, 4'd2);
    mw_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      adv(i < 3 ? 1'b0 : 1'b1);
      if (MemWrite) mw_cnt++;
      if (RegWrite) rw_cnt++;
    end
    chk("sw_memwrite_cycles", mw_cnt, 4);
    chk("sw_regwrite_cycles", rw_cnt, 0);
    chk("sw_back_fetch", State, 4'd0);

    // beq, taken then not taken
    op = OpBranch; Zero = 1'b1;
    adv(1'b1); adv(1'b1);
    chk("beq_state", State, 4'd9);
    chk("beq_pcwrite_z1", PCWrite, 1'b1);
    chk("beq_aluctl", ALUControl, 3'b001);
    #1 Zero = 1'b0;
    #1 chk("beq_pcwrite_z0", PCWrite, 1'b0);
    adv(1'b1); chk("beq_back_fetch", State, 4'd0);

    // R-type sub, then add via funct7b5
    op = OpRtype; funct3 = 3'b000; funct7b5 = 1'b1;
    adv(1'b1); adv(1'b1);
    chk("r_execr", State, 4'd6);
    chk("r_sub_ctl", ALUControl, 3'b001);
    #1 funct7b5 = 1'b0;
    #1 chk("r_add_ctl", ALUControl, 3'b000);
    adv(1'b1); chk("r_aluwb", State, 4'd8); chk("r_aluwb_rw", RegWrite, 1'b1);
    adv(1'b1); chk("r_back_fetch", State, 4'd0);

    // reset asserted mid-instruction in EXECR
    adv(1'b1); adv(1'b1);
    chk("mid_execr", State, 4'd6);
    #1 reset = 1'b1;
    #1 chk("mid_rst_state", State, 4'd0);
    chk("mid_rst_pcwrite", PCWrite, 1'b0);
    chk("mid_rst_irwrite", IRWrite, 1'b0);
    chk("mid_rst_regwrite", RegWrite, 1'b0);
    chk("mid_rst_memwrite", MemWrite, 1'b0);
    @(negedge clk);
    chk("mid_rst_hold_state", State, 4'd0);
    chk("mid_rst_hold_irwrite", IRWrite, 1'b0);
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk); chk("mid_rst_release", IRWrite, 1'b1);

    // unknown opcode
    op = 7'b1111111;
    adv(1'b1); chk("ill_decode", State, 4'd1);
    adv(1'b1);
    if (TrapEn) begin
      chk("ill_trap_state", State, 4'd11);
      chk("ill_trap_flag", Illegal, 1'b1);
      adv(1'b1);
      chk("ill_trap_held", State, 4'd11);
      chk("ill_trap_irwrite", IRWrite, 1'b0);
      chk("ill_trap_pcwrite", PCWrite, 1'b0);
    end else begin
      chk("ill_nop_state", State, 4'd0);
      chk("ill_nop_flag", Illegal, 1'b0);
      chk("ill_nop_regwrite", RegWrite, 1'b0);
    end
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #2;
      reset    = ($urandom_range(0, 59) == 0);
      MemReady = ($urandom_range(0, 3) != 0);
      Zero     = 1'($urandom);
      funct3   = 3'($urandom);
      funct7b5 = 1'($urandom);
      if (cur == KFetch) begin
        case ($urandom_range(0, 6))
          0: op = OpLoad;
          1: op = OpStore;
          2: op = OpRtype;
          3: op = OpItype;
          4: op = OpBranch;
          5: op = OpJal;
          default: op = 7'($urandom);
        endcase
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
